// File: rtl/cache_ctrl_pkg.sv
// Shared address-field constants and request record for the cache controller.
package cache_ctrl_pkg;

    localparam int ADDR_WIDTH          = 32;
    localparam int TAG_BITS            = 23;
    localparam int SET_INDEX_WIDTH     = 5;
    localparam int ELEMENT_WORDS_WIDTH = 2;
    localparam int LINE_WORDS          = 4;

    // Width code used for whole-word moves between cache and memory
    localparam logic [2:0] UBHW_WORD = 3'b010;

    typedef logic [TAG_BITS-1:0]            tag_t;
    typedef logic [SET_INDEX_WIDTH-1:0]     index_t;
    typedef logic [ELEMENT_WORDS_WIDTH-1:0] word_t;

    // One CPU access, captured when it is accepted
    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [2:0]            u_b_h_w;
        logic [31:0]           din;
    } req_t;

    // Word-aligned address of word w of the line (tag, index)
    function automatic logic [ADDR_WIDTH-1:0] line_word_addr(
        input tag_t   tag,
        input index_t index,
        input word_t  w
    );
        return {tag, index, w, 2'b00};
    endfunction

endpackage

// File: rtl/cache_ctrl.sv
// Controller for a 2-way set-associative write-back, write-allocate cache.
// Handles one CPU access at a time; misses write back a dirty LRU victim,
// refill the line word by word from memory, then replay the access.
module cache_ctrl
    import cache_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [2:0]  cpu_u_b_h_w,
    input  logic [31:0] cpu_din,
    output logic [31:0] cpu_dout,
    output logic        cpu_ready,
    output logic        cpu_stall,
    output logic [31:0] cache_addr,
    output logic        cache_load,
    output logic        cache_edit,
    output logic        cache_store,
    output logic        cache_invalid,
    output logic [2:0]  cache_u_b_h_w,
    output logic [31:0] cache_din,
    input  logic        cache_hit,
    input  logic        cache_valid,
    input  logic        cache_dirty,
    input  logic [22:0] cache_tag,
    input  logic [31:0] cache_dout,
    output logic        mem_cs,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    input  logic        mem_ack
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_CHECK  = 3'd2;
    localparam logic [2:0] S_WB_RD  = 3'd3;
    localparam logic [2:0] S_WB_WR  = 3'd4;
    localparam logic [2:0] S_REFILL = 3'd5;

    localparam word_t LAST_WORD = word_t'(LINE_WORDS - 1);

    logic [2:0]  state;
    req_t        req;
    word_t       word_cnt;
    tag_t        victim_tag;
    logic [31:0] wb_buf;
    logic        wb_entry;

    tag_t   req_tag;
    index_t req_index;

    assign req_tag       = req.addr[31:9];
    assign req_index     = req.addr[8:4];
    assign cache_invalid = 1'b0;
    assign cpu_stall     = (state != S_IDLE);

    // Sequencing of lookup, write-back and refill, plus request/victim capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            req        <= '0;
            word_cnt   <= '0;
            victim_tag <= '0;
            wb_buf     <= '0;
            wb_entry   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cpu_req) begin
                        req   <= '{we: cpu_we, addr: cpu_addr, u_b_h_w: cpu_u_b_h_w, din: cpu_din};
                        state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    if (cache_hit) begin
                        state <= S_IDLE;
                    end else begin
                        victim_tag <= cache_tag;
                        word_cnt   <= '0;
                        state      <= (cache_valid && cache_dirty) ? S_WB_RD : S_REFILL;
                    end
                end
                S_WB_RD: begin
                    wb_entry <= 1'b1;
                    state    <= S_WB_WR;
                end
                S_WB_WR: begin
                    wb_entry <= 1'b0;
                    if (wb_entry) begin
                        wb_buf <= cache_dout;
                    end
                    if (mem_ack) begin
                        word_cnt <= word_cnt + word_t'(1);
                        state    <= (word_cnt == LAST_WORD) ? S_REFILL : S_WB_RD;
                    end
                end
                S_REFILL: begin
                    if (mem_ack) begin
                        word_cnt <= word_cnt + word_t'(1);
                        if (word_cnt == LAST_WORD) begin
                            state <= S_LOOKUP;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Cache, memory and CPU-side outputs decoded from the current state
    always_comb begin
        cpu_dout      = '0;
        cpu_ready     = 1'b0;
        cache_addr    = '0;
        cache_load    = 1'b0;
        cache_edit    = 1'b0;
        cache_store   = 1'b0;
        cache_u_b_h_w = '0;
        cache_din     = '0;
        mem_cs        = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_din       = '0;
        case (state)
            S_LOOKUP: begin
                cache_addr    = req.addr;
                cache_u_b_h_w = req.u_b_h_w;
                if (req.we) begin
                    cache_edit = 1'b1;
                    cache_din  = req.din;
                end else begin
                    cache_load = 1'b1;
                end
            end
            S_CHECK: begin
                cpu_ready = cache_hit;
                if (cache_hit && !req.we) begin
                    cpu_dout = cache_dout;
                end
            end
            S_WB_RD: begin
                cache_addr    = line_word_addr(req_tag, req_index, word_cnt);
                cache_u_b_h_w = UBHW_WORD;
            end
            S_WB_WR: begin
                cache_addr    = line_word_addr(req_tag, req_index, word_cnt);
                cache_u_b_h_w = UBHW_WORD;
                mem_cs        = 1'b1;
                mem_we        = 1'b1;
                mem_addr      = line_word_addr(victim_tag, req_index, word_cnt);
                mem_din       = wb_entry ? cache_dout : wb_buf;
            end
            S_REFILL: begin
                cache_addr    = line_word_addr(req_tag, req_index, word_cnt);
                cache_u_b_h_w = UBHW_WORD;
                mem_cs        = 1'b1;
                mem_addr      = line_word_addr(req_tag, req_index, word_cnt);
                if (mem_ack) begin
                    cache_store = 1'b1;
                    cache_din   = mem_dout;
                end
            end
            default: begin
            end
        endcase
    end

endmodule
